store_checker: RTL

STORE_CHECKER -- requirements
Module: store_checker

---
 rtl/store_checker.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/store_checker.sv
// Store checker: compares observed stores against a programmed, in-order table of
// expected (address, data) pairs, skipping a scratch address window, and reports
// pass, mismatch or timeout one clock after the deciding cycle.
module store_checker #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [WIDTH-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [CW-1:0]    cfg_len,
  input  logic [WIDTH-1:0] ign_lo,
  input  logic [WIDTH-1:0] ign_hi,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [CW-1:0]    match_count,
  output logic [31:0]      cycle_count,
  output logic [WIDTH-1:0] fail_addr
);

  typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

  localparam logic [CW-1:0] DepthC      = CW'(DEPTH);
  // Only meaningful when TIMEOUT != 0; the wrap for TIMEOUT == 0 is never used.
  localparam logic [31:0]   TimeoutLast = 32'(TIMEOUT - 1);

  localparam logic [1:0] CodeNone    = 2'd0;
  localparam logic [1:0] CodeAddr    = 2'd1;
  localparam logic [1:0] CodeData    = 2'd2;
  localparam logic [1:0] CodeTimeout = 2'd3;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_addr_q [DEPTH];
  logic [WIDTH-1:0] exp_data_q [DEPTH];
  logic [CW-1:0]    len_q, len_d;
  logic [CW-1:0]    match_q, match_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [1:0]       code_q, code_d;
  logic [WIDTH-1:0] faddr_q, faddr_d;
  logic             busy_q, done_q, pass_q;

  logic [CW-1:0]    start_len;
  logic [WIDTH-1:0] cur_addr, cur_data;
  logic             ignored, timeout_hit, idx_ok;

  // Operand decode for the current expectation and the scratch window.
  always_comb begin
    start_len   = (cfg_len > DepthC) ? DepthC : cfg_len;
    // match_q < len_q <= DEPTH whenever this is used, so the index is in range.
    cur_addr    = exp_addr_q[match_q[IW-1:0]];
    cur_data    = exp_data_q[match_q[IW-1:0]];
    ignored     = (ign_lo <= ign_hi) && (ign_lo <= dataadr) && (dataadr <= ign_hi);
    timeout_hit = (TIMEOUT != 0) && (cyc_q == TimeoutLast);
    idx_ok      = (32'(cfg_idx) < DEPTH);
  end

  // Next-state and next-output logic for the run FSM.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    match_d = match_q;
    cyc_d   = cyc_q;
    code_d  = code_q;
    faddr_d = faddr_q;
    unique case (state_q)
      StIdle, StPass, StFail: begin
        if (start) begin
          len_d   = start_len;
          match_d = '0;
          cyc_d   = '0;
          code_d  = CodeNone;
          faddr_d = '0;
          state_d = (start_len == '0) ? StPass : StRun;
        end
      end
      StRun: begin
        if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
        if (memwrite && !ignored) begin
          if (dataadr != cur_addr) begin
            state_d = StFail;
            code_d  = CodeAddr;
            faddr_d = dataadr;
          end else if (writedata != cur_data) begin
            state_d = StFail;
            code_d  = CodeData;
            faddr_d = dataadr;
          end else begin
            match_d = match_q + 1'b1;
            // A completing match wins over a coincident timeout.
            if (match_d == len_q) begin
              state_d = StPass;
            end else if (timeout_hit) begin
              state_d = StFail;
              code_d  = CodeTimeout;
              faddr_d = '0;
            end
          end
        end else if (timeout_hit) begin
          state_d = StFail;
          code_d  = CodeTimeout;
          faddr_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      match_q <= '0;
      cyc_q   <= '0;
      code_q  <= CodeNone;
      faddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      match_q <= match_d;
      cyc_q   <= cyc_d;
      code_q  <= code_d;
      faddr_q <= faddr_d;
      busy_q  <= (state_d == StRun);
      done_q  <= (state_d == StPass) || (state_d == StFail);
      pass_q  <= (state_d == StPass);
    end
  end

  // Expected-store table; frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        exp_addr_q[i] <= '0;
        exp_data_q[i] <= '0;
      end
    end else if (cfg_we && (state_q != StRun) && idx_ok) begin
      exp_addr_q[cfg_idx] <= cfg_addr;
      exp_data_q[cfg_idx] <= cfg_data;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = code_q;
  assign match_count = match_q;
  assign cycle_count = cyc_q;
  assign fail_addr   = faddr_q;

endmodule
